jump_game_fsm: RTL and testbench

Parametrised top-level game-flow controller for the Doodle-Jump design: menu, loading, play, pause, platform refresh and a new game-over state. Counts frames in the Clock domain from a frame strobe, edge-detects keyboard presses, bounds the refresh wait with a timeout, and drives the screen-select code consumed by the colour mapper and platform logic.

---
 rtl/jump_game_fsm_pkg.sv | 47 ++++
 rtl/jump_game_fsm_if.sv | 24 ++
 rtl/jump_game_fsm_frame_counter.sv | 33 +++
 rtl/jump_game_fsm.sv | 104 ++++++++++
 tb/tb_jump_game_fsm.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/jump_game_fsm_pkg.sv
// Shared types and constants for the Doodle-Jump game-flow controller.
// State encodings double as the screen-select codes driven on outstate.
package jump_game_fsm_pkg;

   typedef enum logic [2:0] {
      StMainMenu   = 3'b000,
      StLoading    = 3'b001,
      StGame       = 3'b010,
      StPause      = 3'b011,
      StRefreshing = 3'b100,
      StInit       = 3'b101,
      StGameOver   = 3'b110
   } state_e;

   localparam logic [2:0] ScrMenu     = 3'b000;
   localparam logic [2:0] ScrLoading  = 3'b001;
   localparam logic [2:0] ScrGame     = 3'b010;
   localparam logic [2:0] ScrPause    = 3'b011;
   localparam logic [2:0] ScrRefresh  = 3'b100;
   localparam logic [2:0] ScrInit     = 3'b101;
   localparam logic [2:0] ScrGameOver = 3'b110;

   localparam logic [7:0] KeySpace = 8'd44;
   localparam logic [7:0] KeyEsc   = 8'd41;

   function automatic logic [2:0] screen_code(state_e s);
      logic [2:0] code;
      unique case (s)
         StMainMenu:   code = ScrMenu;
         StLoading:    code = ScrLoading;
         StGame:       code = ScrGame;
         StPause:      code = ScrPause;
         StRefreshing: code = ScrRefresh;
         StInit:       code = ScrInit;
         StGameOver:   code = ScrGameOver;
         default:      code = ScrInit;
      endcase
      return code;
   endfunction

   function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/jump_game_fsm_if.sv
// Game-flow controller signal bundle: frame/key/playfield inputs and screen outputs.
interface jump_game_fsm_if;

   logic       frame_tick;
   logic [7:0] Keycode;
   logic       refresh_en;
   logic       trigger;
   logic       player_dead;
   logic [2:0] outstate;
   logic       loadplat;
   logic       new_game;
   logic       refresh_timeout;

   modport master (
      output frame_tick, Keycode, refresh_en, trigger, player_dead,
      input  outstate, loadplat, new_game, refresh_timeout
   );

   modport slave (
      input  frame_tick, Keycode, refresh_en, trigger, player_dead,
      output outstate, loadplat, new_game, refresh_timeout
   );

endinterface

// File: rtl/jump_game_fsm_frame_counter.sv
// Saturating frame counter with synchronous clear; clear wins over tick.
module frame_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             clr,
   input  logic             tick,
   output logic [Width-1:0] out
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out = cnt_q;

endmodule

// File: rtl/jump_game_fsm.sv
// Top-level Doodle-Jump game-flow FSM: menu, loading, play, pause, refresh, game over.
// Keys are edge-detected against the previous cycle's keycode so held keys fire once.
module jump_game_fsm
   import jump_game_fsm_pkg::*;
#(
   parameter int unsigned LOAD_FRAMES     = 60,
   parameter int unsigned REFRESH_TIMEOUT = 120,
   parameter int unsigned OVER_HOLD       = 90,
   parameter logic [7:0]  KEY_START       = KeySpace,
   parameter logic [7:0]  KEY_PAUSE       = KeyEsc
) (
   input logic           Clock,
   input logic           Reset,
   jump_game_fsm_if.slave bus
);

   localparam int unsigned MaxFrames = max3(LOAD_FRAMES, REFRESH_TIMEOUT, OVER_HOLD);
   localparam int unsigned CNT_W     = $clog2(MaxFrames) + 1;

   localparam logic [CNT_W-1:0] LoadCnt    = CNT_W'(LOAD_FRAMES);
   localparam logic [CNT_W-1:0] RefreshCnt = CNT_W'(REFRESH_TIMEOUT);
   localparam logic [CNT_W-1:0] HoldCnt    = CNT_W'(OVER_HOLD);

   state_e           state_q, state_d;
   logic [7:0]       prev_key_q;
   logic             new_game_q, new_game_d;
   logic             rto_q, rto_d;
   logic             rto_set;
   logic             press_start, press_pause;
   logic             cnt_clr, cnt_tick;
   logic [CNT_W-1:0] count;

   assign press_start = (bus.Keycode == KEY_START) && (prev_key_q != KEY_START);
   assign press_pause = (bus.Keycode == KEY_PAUSE) && (prev_key_q != KEY_PAUSE);

   always_comb begin
      state_d = state_q;
      rto_set = 1'b0;
      unique case (state_q)
         StInit:     state_d = StMainMenu;
         StMainMenu: if (press_start) state_d = StLoading;
         StLoading:  if (count == LoadCnt) state_d = StGame;
         StGame: begin
            if (bus.player_dead) begin
               state_d = StGameOver;
            end else if (press_pause) begin
               state_d = StPause;
            end else if (bus.refresh_en) begin
               state_d = StRefreshing;
            end
         end
         StPause:    if (press_pause) state_d = StGame;
         StRefreshing: begin
            // A trigger arriving on the timeout cycle counts as a normal completion.
            if (bus.trigger) begin
               state_d = StGame;
            end else if (count == RefreshCnt) begin
               state_d = StGame;
               rto_set = 1'b1;
            end
         end
         StGameOver: if (press_start && (count >= HoldCnt)) state_d = StLoading;
         default:    state_d = StInit;
      endcase

      new_game_d = (state_d == StLoading) && (state_q != StLoading);
      rto_d      = new_game_d ? 1'b0 : (rto_q | rto_set);
   end

   assign cnt_clr  = (state_d != state_q);
   assign cnt_tick = bus.frame_tick &&
                     ((state_q == StLoading) || (state_q == StRefreshing) ||
                      (state_q == StGameOver));

   frame_counter #(
      .Width(CNT_W)
   ) u_cnt (
      .Clock(Clock),
      .Reset(Reset),
      .clr  (cnt_clr),
      .tick (cnt_tick),
      .out  (count)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q    <= StInit;
         prev_key_q <= 8'd0;
         new_game_q <= 1'b0;
         rto_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_key_q <= bus.Keycode;
         new_game_q <= new_game_d;
         rto_q      <= rto_d;
      end
   end

   assign bus.outstate        = screen_code(state_q);
   assign bus.loadplat        = (state_q == StLoading);
   assign bus.new_game        = new_game_q;
   assign bus.refresh_timeout = rto_q;

endmodule

// File: tb/tb_jump_game_fsm.sv
// Scoreboard bench for jump_game_fsm: stimulus pushes expected outputs, a monitor
// pops one entry per falling edge and compares it against the DUT.
module tb_jump_game_fsm;

   logic Clock = 1'b0;
   logic Reset = 1'b1;

   always #5 Clock = ~Clock;

   jump_game_fsm_if bus ();

   jump_game_fsm dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus)
   );

   typedef struct {
      string      name;
      logic [2:0] os;
      logic       lp;
      logic       ng;
      logic       rto;
      bit         chk_cnt;
      int         cnt;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic cmp(string name, string field, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s.%s: got %0d want %0d", name, field, act, req);
      end
   endtask

   initial begin
      forever begin
         @(negedge Clock);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "outstate", int'(bus.outstate), int'(e.os));
            cmp(e.name, "loadplat", int'(bus.loadplat), int'(e.lp));
            cmp(e.name, "new_game", int'(bus.new_game), int'(e.ng));
            cmp(e.name, "refresh_timeout", int'(bus.refresh_timeout), int'(e.rto));
            if (e.chk_cnt) cmp(e.name, "count", int'(dut.count), e.cnt);
         end
      end
   end

   task automatic push(string n, logic [2:0] os, logic lp, logic ng, logic rto,
                       bit cc = 1'b0, int c = 0);
      exp_t e;
      e.name = n; e.os = os; e.lp = lp; e.ng = ng; e.rto = rto; e.chk_cnt = cc; e.cnt = c;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) begin
         bus.frame_tick = 1'b1;
         step();
         bus.frame_tick = 1'b0;
         step();
      end
   endtask

   initial begin
      bus.frame_tick  = 1'b0;
      bus.Keycode     = 8'd0;
      bus.refresh_en  = 1'b0;
      bus.trigger     = 1'b0;
      bus.player_dead = 1'b0;

      // Reset and idle
      step(); step();
      push("reset", 3'b101, 0, 0, 0, 1, 0);
      step();
      Reset = 1'b0;
      push("init_hold", 3'b101, 0, 0, 0);
      step();
      push("menu", 3'b000, 0, 0, 0);
      bus.Keycode = 8'd41;
      step();
      push("menu_esc", 3'b000, 0, 0, 0);
      bus.Keycode = 8'd0;
      step();

      // Start and load
      bus.Keycode = 8'd44;
      step();
      push("load_entry", 3'b001, 1, 1, 0, 1, 0);
      step();
      push("load_held", 3'b001, 1, 0, 0);
      bus.Keycode = 8'd0;
      ticks(59);
      push("load_59", 3'b001, 1, 0, 0, 1, 59);
      ticks(1);
      push("game", 3'b010, 0, 0, 0, 1, 0);

      // Pause with held esc, other keys ignored
      bus.Keycode = 8'd41;
      step();
      push("pause", 3'b011, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         step();
         push("pause_hold", 3'b011, 0, 0, 0);
      end
      bus.Keycode = 8'd44;
      step();
      push("pause_space", 3'b011, 0, 0, 0);
      bus.Keycode = 8'd0;
      step();
      push("pause_rel", 3'b011, 0, 0, 0);
      bus.Keycode = 8'd41;
      step();
      push("unpause", 3'b010, 0, 0, 0);
      bus.Keycode = 8'd0;
      step();

      // Refresh: trigger on the timeout cycle leaves the flag clear
      bus.refresh_en = 1'b1;
      step();
      push("refr_a", 3'b100, 0, 0, 0, 1, 0);
      bus.refresh_en = 1'b0;
      ticks(119);
      push("refr_a_119", 3'b100, 0, 0, 0, 1, 119);
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      bus.trigger = 1'b1;
      step();
      bus.trigger = 1'b0;
      push("refr_trig_edge", 3'b010, 0, 0, 0);

      // Refresh with no trigger times out
      bus.refresh_en = 1'b1;
      step();
      push("refr_b", 3'b100, 0, 0, 0);
      bus.refresh_en = 1'b0;
      ticks(120);
      push("refr_timeout", 3'b010, 0, 0, 1);
      step();
      push("rto_sticky", 3'b010, 0, 0, 1);

      // Death beats esc; hold window ignores early start presses
      bus.player_dead = 1'b1;
      bus.Keycode = 8'd41;
      step();
      push("over", 3'b110, 0, 0, 1, 1, 0);
      bus.player_dead = 1'b0;
      bus.Keycode = 8'd0;
      ticks(50);
      bus.Keycode = 8'd44;
      step();
      push("over_50", 3'b110, 0, 0, 1, 1, 50);
      bus.Keycode = 8'd0;
      step();
      ticks(39);
      bus.Keycode = 8'd44;
      step();
      push("over_89", 3'b110, 0, 0, 1, 1, 89);
      bus.Keycode = 8'd0;
      step();
      ticks(1);
      bus.Keycode = 8'd44;
      step();
      push("restart", 3'b001, 1, 1, 0, 1, 0);
      bus.Keycode = 8'd0;

      // Reset mid-loading
      step();
      ticks(30);
      push("load_30", 3'b001, 1, 0, 0, 1, 30);
      @(negedge Clock);
      #1;
      Reset = 1'b1;
      #1;
      push("rst_mid", 3'b101, 0, 0, 0, 1, 0);
      step(); step();
      Reset = 1'b0;
      push("init_again", 3'b101, 0, 0, 0);
      step();
      push("menu_again", 3'b000, 0, 0, 0);
      bus.Keycode = 8'd44;
      step();
      push("load_again", 3'b001, 1, 1, 0, 1, 0);
      bus.Keycode = 8'd0;
      ticks(59);
      push("reload_59", 3'b001, 1, 0, 0, 1, 59);
      ticks(1);
      push("game_again", 3'b010, 0, 0, 0);

      for (int i = 0; i < 20 && sb.size() > 0; i++) begin
         @(negedge Clock);
         #1;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
